// File: rtl/tx_quadro_serial_pkg.sv
// Shared definitions for the camera-side frame streamer: state codes, frame geometry and
// link defaults.
package tx_quadro_serial_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitPixel = 3'd1,
    StStart     = 3'd2,
    StData      = 3'd3,
    StStop      = 3'd4,
    StFim       = 3'd5
  } estado_t;

  localparam int unsigned DefLines    = 120;
  localparam int unsigned DefColumns  = 320;
  localparam int unsigned DefBaudDiv  = 434;
  localparam logic [7:0]  DefReqByte  = 8'hFF;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tx_quadro_serial_tx_serial_8n1.sv
// UART 8N1 byte serializer: start bit, eight data bits LSB first, stop bit, each BAUD_DIV cycles.
// partida loads a byte while idle; pronto strobes on the last cycle of the stop bit.
module tx_quadro_serial_tx_serial_8n1
  import tx_quadro_serial_pkg::*;
#(
  parameter int unsigned BAUD_DIV = DefBaudDiv
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [7:0] dados,
  output logic       saida,
  output logic       pronto,
  output logic [2:0] fase_prox
);

  localparam int unsigned     BaudW   = cnt_width(BAUD_DIV);
  localparam logic [BaudW-1:0] BaudMax = BaudW'(BAUD_DIV - 1);

  estado_t          fase_q, fase_d;
  logic [BaudW-1:0] baud_q, baud_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             saida_q, saida_d;
  logic             baud_fim;

  assign baud_fim = (baud_q == BaudMax);

  always_comb begin
    fase_d  = fase_q;
    baud_d  = baud_q + BaudW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    saida_d = saida_q;
    pronto  = 1'b0;
    case (fase_q)
      StIdle: begin
        baud_d  = '0;
        saida_d = 1'b1;
        if (partida) begin
          fase_d  = StStart;
          shift_d = dados;
          saida_d = 1'b0;
        end
      end
      StStart: begin
        if (baud_fim) begin
          fase_d  = StData;
          baud_d  = '0;
          bit_d   = '0;
          saida_d = shift_q[0];
        end
      end
      StData: begin
        if (baud_fim) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            fase_d  = StStop;
            saida_d = 1'b1;
          end else begin
            // Next bit is shift_q[1] because the register shifts on this same edge.
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            saida_d = shift_q[1];
          end
        end
      end
      StStop: begin
        if (baud_fim) begin
          fase_d = StIdle;
          baud_d = '0;
          pronto = 1'b1;
        end
      end
      default: begin
        fase_d  = StIdle;
        baud_d  = '0;
        saida_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fase_q  <= StIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      saida_q <= 1'b1;
    end else begin
      fase_q  <= fase_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      saida_q <= saida_d;
    end
  end

  assign saida     = saida_q;
  assign fase_prox = fase_d;

endmodule

// File: rtl/tx_quadro_serial.sv
// Frame streamer: on the capture-request byte, fetches and serializes LINES x COLUMNS pixels
// row-major over UART 8N1, then pulses fim_quadro.
module tx_quadro_serial
  import tx_quadro_serial_pkg::*;
#(
  parameter int unsigned LINES    = DefLines,
  parameter int unsigned COLUMNS  = DefColumns,
  parameter int unsigned S_LINE   = 7,
  parameter int unsigned S_COLUMN = 9,
  parameter int unsigned BAUD_DIV = DefBaudDiv,
  parameter logic [7:0]  REQ_BYTE = DefReqByte
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  input  logic [7:0]          req_byte,
  input  logic                pixel_valid,
  input  logic [7:0]          pixel_byte,
  output logic                pixel_req,
  output logic                saida_serial,
  output logic                busy,
  output logic                fim_quadro,
  output logic [S_LINE-1:0]   linha,
  output logic [S_COLUMN-1:0] coluna,
  output logic [2:0]          db_estado
);

  localparam logic [S_LINE-1:0]   LastLine   = S_LINE'(LINES - 1);
  localparam logic [S_COLUMN-1:0] LastColumn = S_COLUMN'(COLUMNS - 1);

  estado_t             state_q, state_d;
  logic [S_LINE-1:0]   linha_q, linha_d;
  logic [S_COLUMN-1:0] coluna_q, coluna_d;
  logic                pixel_req_q, busy_q, fim_q;
  logic                req_ok, ultimo, partida, pronto;
  logic [2:0]          fase_prox;

  assign req_ok  = req_valid && (req_byte == REQ_BYTE);
  assign ultimo  = (linha_q == LastLine) && (coluna_q == LastColumn);
  assign partida = (state_q == StWaitPixel) && pixel_valid;

  tx_quadro_serial_tx_serial_8n1 #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx (
    .clock     (clock),
    .reset     (reset),
    .partida   (partida),
    .dados     (pixel_byte),
    .saida     (saida_serial),
    .pronto    (pronto),
    .fase_prox (fase_prox)
  );

  always_comb begin
    state_d  = state_q;
    linha_d  = linha_q;
    coluna_d = coluna_q;
    case (state_q)
      StIdle: begin
        if (req_ok) begin
          state_d  = StWaitPixel;
          linha_d  = '0;
          coluna_d = '0;
        end
      end
      StWaitPixel: begin
        if (pixel_valid) state_d = StStart;
      end
      StStart, StData, StStop: begin
        // The serializer owns bit timing; the frame FSM tracks its phase for db_estado.
        if (pronto) begin
          if (ultimo) begin
            state_d = StFim;
          end else begin
            state_d = StWaitPixel;
            if (coluna_q == LastColumn) begin
              coluna_d = '0;
              linha_d  = linha_q + S_LINE'(1);
            end else begin
              coluna_d = coluna_q + S_COLUMN'(1);
            end
          end
        end else begin
          state_d = estado_t'(fase_prox);
        end
      end
      StFim:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      linha_q     <= '0;
      coluna_q    <= '0;
      pixel_req_q <= 1'b0;
      busy_q      <= 1'b0;
      fim_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      linha_q     <= linha_d;
      coluna_q    <= coluna_d;
      pixel_req_q <= (state_d == StWaitPixel);
      busy_q      <= (state_d != StIdle);
      fim_q       <= (state_d == StFim);
    end
  end

  assign pixel_req  = pixel_req_q;
  assign busy       = busy_q;
  assign fim_quadro = fim_q;
  assign linha      = linha_q;
  assign coluna     = coluna_q;
  assign db_estado  = state_q;

endmodule

// File: tb/tb_tx_quadro_serial.sv
// Directed bench for tx_quadro_serial on a 2x3 frame with 4 cycles per bit.
module tb_tx_quadro_serial;

  logic       clock = 1'b0;
  logic       reset;
  logic       req_valid;
  logic [7:0] req_byte;
  logic       pixel_valid;
  logic [7:0] pixel_byte;
  logic       pixel_req;
  logic       saida_serial;
  logic       busy;
  logic       fim_quadro;
  logic [6:0] linha;
  logic [8:0] coluna;
  logic [2:0] db_estado;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int fim_count = 0;

  typedef struct {
    logic [7:0] pix;
    int         lin;
    int         col;
  } vec_t;
  vec_t tbl[6];

  tx_quadro_serial #(
    .LINES    (2),
    .COLUMNS  (3),
    .S_LINE   (7),
    .S_COLUMN (9),
    .BAUD_DIV (4),
    .REQ_BYTE (8'hFF)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_byte     (req_byte),
    .pixel_valid  (pixel_valid),
    .pixel_byte   (pixel_byte),
    .pixel_req    (pixel_req),
    .saida_serial (saida_serial),
    .busy         (busy),
    .fim_quadro   (fim_quadro),
    .linha        (linha),
    .coluna       (coluna),
    .db_estado    (db_estado)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (fim_quadro === 1'b1) fim_count <= fim_count + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
    else pass_cnt++;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_saida"}, saida_serial, 1);
    check({tag, "_pixel_req"}, pixel_req, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_db_estado"}, db_estado, 0);
  endtask

  task automatic wait_start(output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (saida_serial !== 1'b0 && waited < 200);
  endtask

  // Streams one frame; stall_k / req_k / rst_k select the pixel where a stall, a stray
  // request or a reset is injected (-1 for none).
  task automatic run_frame(input int stall_k, input int req_k, input int rst_k);
    int         waited;
    int         fim_base;
    logic [9:0] frame;
    fim_base    = fim_count;
    req_byte    = 8'hFF;
    req_valid   = 1'b1;
    pixel_valid = 1'b1;
    pixel_byte  = tbl[0].pix;
    tick();
    req_valid = 1'b0;
    check("req_pixel_req", pixel_req, 1);
    check("req_busy", busy, 1);
    check("req_db_estado", db_estado, 1);
    for (int k = 0; k < 6; k++) begin
      wait_start(waited);
      check("start_wait", waited, 1);
      if (saida_serial !== 1'b0) return;
      check("linha_at_start", linha, tbl[k].lin);
      check("coluna_at_start", coluna, tbl[k].col);
      check("db_start", db_estado, 2);
      if (k < 5) pixel_byte = tbl[k + 1].pix;
      frame = {1'b1, tbl[k].pix, 1'b0};
      for (int i = 0; i < 40; i++) begin
        if (i > 0) tick();
        check("serial_bit", saida_serial, frame[i / 4]);
        if (i == 4) check("db_data", db_estado, 3);
        if (i == 36) check("db_stop", db_estado, 4);
        if (k == req_k && i == 12) begin
          req_byte  = 8'hFF;
          req_valid = 1'b1;
        end
        if (k == req_k && i == 13) req_valid = 1'b0;
        if (k == rst_k && i == 16) begin
          reset = 1'b1;
          tick();
          reset = 1'b0;
          check_idle("midreset");
          check("midreset_linha", linha, 0);
          check("midreset_coluna", coluna, 0);
          check("midreset_no_fim", fim_count - fim_base, 0);
          return;
        end
      end
      tick();
      if (k < 5) begin
        check("gap_pixel_req", pixel_req, 1);
        check("gap_saida", saida_serial, 1);
        check("gap_no_fim", fim_quadro, 0);
      end else begin
        check("fim_pulse", fim_quadro, 1);
        check("fim_busy", busy, 1);
        check("fim_linha", linha, 1);
        check("fim_coluna", coluna, 2);
      end
      if (k == stall_k) begin
        pixel_valid = 1'b0;
        for (int s = 0; s < 50; s++) begin
          tick();
          check("stall_saida", saida_serial, 1);
          check("stall_pixel_req", pixel_req, 1);
          check("stall_coluna", coluna, tbl[k + 1].col);
        end
        pixel_valid = 1'b1;
      end
    end
    tick();
    check("post_fim_low", fim_quadro, 0);
    check_idle("post_frame");
    check("fim_count", fim_count - fim_base, 1);
  endtask

  initial begin
    tbl[0] = '{pix: 8'hA5, lin: 0, col: 0};
    tbl[1] = '{pix: 8'h3C, lin: 0, col: 1};
    tbl[2] = '{pix: 8'h01, lin: 0, col: 2};
    tbl[3] = '{pix: 8'h80, lin: 1, col: 0};
    tbl[4] = '{pix: 8'hFF, lin: 1, col: 1};
    tbl[5] = '{pix: 8'h00, lin: 1, col: 2};

    reset       = 1'b1;
    req_valid   = 1'b0;
    req_byte    = 8'h00;
    pixel_valid = 1'b0;
    pixel_byte  = 8'h00;
    tick();
    tick();
    check_idle("reset");
    check("reset_fim", fim_quadro, 0);
    check("reset_linha", linha, 0);
    check("reset_coluna", coluna, 0);
    reset = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_idle("idle20");
    end

    // Wrong request byte is ignored.
    req_byte  = 8'h41;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    check_idle("wrong_byte");
    tick();
    check_idle("wrong_byte_next");

    // Reset and a valid request on the same edge: reset wins.
    reset     = 1'b1;
    req_byte  = 8'hFF;
    req_valid = 1'b1;
    tick();
    reset     = 1'b0;
    req_valid = 1'b0;
    check_idle("reset_vs_req");
    tick();
    check_idle("reset_vs_req_next");

    run_frame(-1, -1, -1);
    run_frame(1, -1, -1);
    run_frame(-1, 2, -1);
    run_frame(-1, -1, 3);
    run_frame(-1, -1, -1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tx_quadro_serial.md
# tx_quadro_serial

Camera-side frame streamer; the other end of the capture link. Waits for the capture-request byte on the serial receive path, then fetches one byte per pixel from a pixel source by handshake and serializes every pixel of a LINES×COLUMNS frame, row-major, as UART 8N1 on its serial output. Signals frame completion and returns to idle. It is the counterpart of the capture interface, which sends the request byte and samples the received pixel stream.

## Interface
- LINES, 120, frame lines
- COLUMNS, 320, frame columns
- S_LINE, 7, line counter width
- S_COLUMN, 9, column counter width
- BAUD_DIV, 434, clock cycles per serial bit (50 MHz / 115200)
- REQ_BYTE, 8'hFF, capture-request byte value

- clock  in  1  system clock
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high
- req_valid  in  1  one-cycle strobe: req_byte holds a received byte
- req_byte  in  8  received byte, from rx_serial_8N1
- pixel_valid  in  1  pixel source has pixel_byte available
- pixel_byte  in  8  current pixel byte
- pixel_req  out  1  block is waiting for a pixel byte
- saida_serial  out  1  UART 8N1 output, idle high
- busy  out  1  frame in progress
- fim_quadro  out  1  one-cycle pulse after the last stop bit
- linha  out  S_LINE  line index of the pixel being sent
- coluna  out  S_COLUMN  column index of the pixel being sent
- db_estado  out  3  state code

## Operation
- States and codes: IDLE=0, WAIT_PIXEL=1, START=2, DATA=3, STOP=4, FIM=5.
- IDLE: saida_serial=1, busy=0, pixel_req=0.
  - req_valid=1 and req_byte==REQ_BYTE: linha=0, coluna=0, go to WAIT_PIXEL.
  - Any other byte is ignored.
- WAIT_PIXEL: pixel_req=1, busy=1.
  - A pixel is accepted on an edge where pixel_valid=1.
  - On acceptance, pixel_byte is latched into the shift register and the state goes to START.
  - There is no timeout.
- START: saida_serial=0 for BAUD_DIV cycles.
- DATA: 8 bits, LSB first, each held for BAUD_DIV cycles. A 3-bit bit counter is used.
- STOP: saida_serial=1 for BAUD_DIV cycles. At the end of STOP:
  - Pixel (LINES-1, COLUMNS-1): go to FIM.
  - Otherwise, advance to the next pixel and go to WAIT_PIXEL. coluna increments; at COLUMNS-1 it wraps to 0 and linha increments.
- FIM: fim_quadro=1 for exactly one cycle, then IDLE. Counters keep their last value until the next request.
- Requests arriving while busy=1 (any state other than IDLE) are ignored.
- Baud counter: counts 0..BAUD_DIV-1. It is cleared on entry to START, DATA (each bit) and STOP.

## Timing
- All outputs are registered, Moore style.
- Reset values: saida_serial=1, pixel_req=0, busy=0, fim_quadro=0, linha=0, coluna=0, db_estado=0.
- Request to pixel_req: pixel_req is high the cycle after the req_valid edge.
- Pixel acceptance to start bit: saida_serial falls the cycle after the accepting edge.
- Byte duration: exactly 10×BAUD_DIV cycles, from start-bit low to the end of the stop bit.
- Inter-byte gap: at least 1 cycle, high, spent in WAIT_PIXEL. The gap stretches while pixel_valid=0.
- fim_quadro: asserted the cycle after the last stop bit ends. busy drops together with fim_quadro deassertion.
- Reset mid-frame: next cycle is IDLE with saida_serial=1 and counters at 0. A truncated byte is acceptable; the receiver sees a framing error or timeout.
- req_valid coincident with reset: reset wins.

## Structure
- Shared package holds:
  - state codes
  - default BAUD_DIV
  - REQ_BYTE
  - LINES, COLUMNS
- Sub-module tx_serial_8N1 (shift register, bit counter, baud counter, start/stop framing, `partida`/`pronto` handshake) is the natural split.
- The top FSM then owns the request match, pixel handshake and contador_m line/column counters.

## Test plan
Bench parameters: LINES=2, COLUMNS=3, BAUD_DIV=4.

1. Reset, then idle 20 cycles -> saida_serial=1, pixel_req=0, busy=0, db_estado=0.
2. req_byte=8'h41 with req_valid -> stays IDLE, no pixel_req.
3. req_byte=8'hFF, then pixel_valid always 1 with pixel_byte=8'hA5 -> saida_serial shows 0,1,0,1,0,0,1,0,1, each bit 4 cycles long, then the stop bit. 6 bytes are sent; fim_quadro pulses once; linha=1, coluna=2 at fim_quadro.
4. pixel_valid held 0 for 50 cycles mid-frame -> saida_serial stays 1, pixel_req stays 1. Streaming resumes one cycle after pixel_valid rises; coluna is unchanged across the stall.
5. Second req_valid 8'hFF during DATA of pixel 2 -> ignored. Frame still ends after 6 bytes with a single fim_quadro.
6. reset asserted during DATA of pixel 3 -> next cycle IDLE, saida_serial=1, linha=0, coluna=0. A new request then sends a full 6-byte frame.
